// File: rtl/metronome_gen_if.sv
// Control and display bundle of the metronome.
//   master: tempo controller side (run, keys, direct tempo load), reads the displays.
//   slave : metronome_gen, drives tempo, BCD digits, beat tick/index, click and LEDs.
// Ports: run, bpm_up_n, bpm_down_n, bpm_load, bpm_in[7:0] towards the metronome;
//        bpm[7:0], bpm_hund/tens/ones[3:0], beat_tick, beat_idx, accent, speaker,
//        led[NUM_LEDS-1:0], busy back from it.
interface metronome_gen_if #(
  parameter int NUM_LEDS = 8,
  parameter int BIDX_W   = 2
);
  logic                run;
  logic                bpm_up_n;
  logic                bpm_down_n;
  logic                bpm_load;
  logic [7:0]          bpm_in;
  logic [7:0]          bpm;
  logic [3:0]          bpm_hund;
  logic [3:0]          bpm_tens;
  logic [3:0]          bpm_ones;
  logic                beat_tick;
  logic [BIDX_W-1:0]   beat_idx;
  logic                accent;
  logic                speaker;
  logic [NUM_LEDS-1:0] led;
  logic                busy;

  modport master (
    output run, bpm_up_n, bpm_down_n, bpm_load, bpm_in,
    input  bpm, bpm_hund, bpm_tens, bpm_ones, beat_tick, beat_idx,
           accent, speaker, led, busy
  );

  modport slave (
    input  run, bpm_up_n, bpm_down_n, bpm_load, bpm_in,
    output bpm, bpm_hund, bpm_tens, bpm_ones, beat_tick, beat_idx,
           accent, speaker, led, busy
  );
endinterface

// File: rtl/metronome_gen.sv
// Tempo generator: beat ticks, accented click, ping-pong LED sweep and a BCD tempo
// readout. Tempo is stepped by two raw keys or loaded directly; the sweep step length
// floor(CLK_HZ*60 / (bpm*S)) comes from a 32-cycle restoring divider.
// Ports: clock, reset (synchronous, active-low), bus (metronome_gen_if.slave).
module metronome_gen #(
  parameter int CLK_HZ        = 50000000,
  parameter int NUM_LEDS      = 8,
  parameter int BPM_MIN       = 40,
  parameter int BPM_MAX       = 240,
  parameter int BPM_STEP      = 10,
  parameter int BPM_DEFAULT   = 120,
  parameter int BEATS_PER_BAR = 4,
  parameter int CLICK_CYCLES  = 250000
) (
  input logic            clock,
  input logic            reset,
  metronome_gen_if.slave bus
);
  localparam int SWEEP  = 2 * (NUM_LEDS - 1);
  localparam int POS_W  = (SWEEP > 1) ? $clog2(SWEEP) : 1;
  localparam int BIDX_W = (BEATS_PER_BAR > 1) ? $clog2(BEATS_PER_BAR) : 1;

  localparam logic [31:0]       DIVIDEND   = 32'(longint'(CLK_HZ) * 64'd60);
  localparam logic [7:0]        MIN8       = 8'(BPM_MIN);
  localparam logic [7:0]        MAX8       = 8'(BPM_MAX);
  localparam logic [8:0]        STEP9      = 9'(BPM_STEP);
  localparam logic [7:0]        DOWN_FLOOR = 8'(BPM_MIN + BPM_STEP);
  localparam logic [POS_W-1:0]  POS_LAST   = POS_W'(SWEEP - 1);
  localparam logic [BIDX_W-1:0] BIDX_LAST  = BIDX_W'(BEATS_PER_BAR - 1);
  localparam logic [31:0]       CLICK_1    = 32'(CLICK_CYCLES);
  localparam logic [31:0]       CLICK_2    = 32'(2 * CLICK_CYCLES);

  // [0],[1] form the synchroniser, [2] holds the previous synchronised level
  logic [2:0]  up_sh, dn_sh;
  logic        press_up, press_dn;
  logic [7:0]  bpm_r, bpm_nx;
  logic [8:0]  up_sum;
  logic [3:0]  hund_r, tens_r, ones_r;

  logic        div_busy, div_done;
  logic [4:0]  div_cnt;
  logic [7:0]  div_bpm;
  logic [31:0] div_den, div_quo, div_rem;
  logic [32:0] rem_sh, rem_diff;
  logic        rem_ge;

  logic        step_valid, pend;
  logic [31:0] pend_val, step_cycles;
  logic [31:0] step_cnt, elapsed;
  logic [POS_W-1:0]  pos;
  logic [BIDX_W-1:0] bidx;
  logic        running, step_end, wrap, spk;
  logic [NUM_LEDS-1:0] led_v;

  assign press_up = up_sh[2] & ~up_sh[1];
  assign press_dn = dn_sh[2] & ~dn_sh[1];
  assign up_sum   = {1'b0, bpm_r} + STEP9;

  always_comb begin
    bpm_nx = bpm_r;
    if (bus.bpm_load) begin
      if (bus.bpm_in < MIN8)      bpm_nx = MIN8;
      else if (bus.bpm_in > MAX8) bpm_nx = MAX8;
      else                        bpm_nx = bus.bpm_in;
    end else if (press_up && !press_dn) begin
      bpm_nx = (up_sum > {1'b0, MAX8}) ? MAX8 : up_sum[7:0];
    end else if (press_dn && !press_up) begin
      bpm_nx = (bpm_r < DOWN_FLOOR) ? MIN8 : bpm_r - 8'(BPM_STEP);
    end
  end

  // One restoring step: shift the next dividend bit into the remainder and subtract
  // if it fits. The remainder is always below the divisor, so a borrow in bit 32
  // means the subtraction did not fit.
  assign rem_sh   = {div_rem, div_quo[31]};
  assign rem_diff = rem_sh - {1'b0, div_den};
  assign rem_ge   = ~rem_diff[32];
  // A finished result only counts if the tempo did not move under it
  assign div_done = div_busy && (div_cnt == 5'd31) && (bpm_r == div_bpm);

  assign running  = bus.run && step_valid;
  assign step_end = (step_cnt == step_cycles - 32'd1);
  assign wrap     = running && step_end && (pos == POS_LAST);
  assign spk      = running && (elapsed < ((bidx == '0) ? CLICK_2 : CLICK_1));

  // Ping-pong: LED i is lit at sweep positions i and S-i
  always_comb begin
    led_v = '0;
    for (int i = 0; i < NUM_LEDS; i++)
      led_v[i] = running && ((int'(pos) == i) || (int'(pos) == SWEEP - i));
  end

  always_ff @(posedge clock) begin
    if (!reset) begin
      up_sh  <= 3'b111;
      dn_sh  <= 3'b111;
      bpm_r  <= 8'(BPM_DEFAULT);
      hund_r <= 4'(BPM_DEFAULT / 100);
      tens_r <= 4'((BPM_DEFAULT / 10) % 10);
      ones_r <= 4'(BPM_DEFAULT % 10);
    end else begin
      up_sh  <= {up_sh[1:0], bus.bpm_up_n};
      dn_sh  <= {dn_sh[1:0], bus.bpm_down_n};
      bpm_r  <= bpm_nx;
      hund_r <= 4'(bpm_r / 8'd100);
      tens_r <= 4'((bpm_r / 8'd10) % 8'd10);
      ones_r <= 4'(bpm_r % 8'd10);
    end
  end

  // Reset primes the divider with the default tempo so it runs straight away
  always_ff @(posedge clock) begin
    if (!reset) begin
      div_busy <= 1'b1;
      div_cnt  <= '0;
      div_bpm  <= 8'(BPM_DEFAULT);
      div_den  <= 32'(BPM_DEFAULT * SWEEP);
      div_quo  <= DIVIDEND;
      div_rem  <= '0;
    end else if (bpm_r != div_bpm) begin
      div_busy <= 1'b1;
      div_cnt  <= '0;
      div_bpm  <= bpm_r;
      div_den  <= 32'(bpm_r) * 32'(SWEEP);
      div_quo  <= DIVIDEND;
      div_rem  <= '0;
    end else if (div_busy) begin
      div_rem  <= rem_ge ? rem_diff[31:0] : rem_sh[31:0];
      div_quo  <= {div_quo[30:0], rem_ge};
      div_cnt  <= div_cnt + 5'd1;
      if (div_cnt == 5'd31) div_busy <= 1'b0;
    end
  end

  // A new step length is applied at once while idle, otherwise held until the
  // current beat wraps so the beat in progress finishes at the old tempo.
  always_ff @(posedge clock) begin
    if (!reset) begin
      step_valid  <= 1'b0;
      pend        <= 1'b0;
      pend_val    <= '0;
      step_cycles <= '0;
    end else if (div_done) begin
      step_valid <= 1'b1;
      if (!running) begin
        step_cycles <= {div_quo[30:0], rem_ge};
        pend        <= 1'b0;
      end else begin
        pend_val <= {div_quo[30:0], rem_ge};
        pend     <= 1'b1;
      end
    end else if (pend && (!running || wrap)) begin
      step_cycles <= pend_val;
      pend        <= 1'b0;
    end
  end

  always_ff @(posedge clock) begin
    if (!reset || !running) begin
      step_cnt <= '0;
      pos      <= '0;
      bidx     <= '0;
      elapsed  <= '0;
    end else begin
      if (wrap)                  elapsed <= '0;
      else if (elapsed != CLICK_2) elapsed <= elapsed + 32'd1;
      if (step_end) begin
        step_cnt <= '0;
        if (pos == POS_LAST) begin
          pos  <= '0;
          bidx <= (bidx == BIDX_LAST) ? '0 : bidx + BIDX_W'(1);
        end else begin
          pos  <= pos + POS_W'(1);
        end
      end else begin
        step_cnt <= step_cnt + 32'd1;
      end
    end
  end

  assign bus.bpm       = bpm_r;
  assign bus.bpm_hund  = hund_r;
  assign bus.bpm_tens  = tens_r;
  assign bus.bpm_ones  = ones_r;
  assign bus.busy      = div_busy;
  // Counters sit at zero whenever stopped, so the first running cycle is a beat start
  assign bus.beat_tick = running && (step_cnt == '0) && (pos == '0);
  assign bus.beat_idx  = running ? bidx : '0;
  assign bus.speaker   = spk;
  assign bus.accent    = spk && (bidx == '0);
  assign bus.led       = led_v;
endmodule

// File: tb/tb_metronome_gen.sv
module tb_metronome_gen;
  localparam int CLK_HZ       = 1200;
  localparam int NUM_LEDS     = 4;
  localparam int CLICK_CYCLES = 10;
  localparam int SWEEP        = 2 * (NUM_LEDS - 1);
  localparam int BPB          = 4;

  logic clock = 1'b0;
  logic reset;

  metronome_gen_if #(.NUM_LEDS(NUM_LEDS), .BIDX_W(2)) bus ();

  metronome_gen #(
    .CLK_HZ(CLK_HZ), .NUM_LEDS(NUM_LEDS), .CLICK_CYCLES(CLICK_CYCLES)
  ) dut (
    .clock(clock), .reset(reset), .bus(bus)
  );

  always #5 clock = ~clock;

  int checks = 0;
  int passes = 0;
  // reference model: tempo, active step length, pending step, position in beat/bar
  int m_bpm, m_step, m_next, m_t, m_beat;
  bit m_pend;

  function automatic int exp_step(input int b);
    return (CLK_HZ * 60) / (b * SWEEP);
  endfunction

  function automatic int clampb(input int v);
    return (v < 40) ? 40 : ((v > 240) ? 240 : v);
  endfunction

  task automatic tick();
    @(posedge clock);
    #1;
  endtask

  task automatic chk(input string tag, input int obs, input int exp);
    checks++;
    assert (obs === exp) passes++;
    else $error("FAIL %s: observed %0d expected %0d", tag, obs, exp);
  endtask

  task automatic chk_bcd(input string tag);
    int e, o;
    e = ((m_bpm / 100) << 8) | (((m_bpm / 10) % 10) << 4) | (m_bpm % 10);
    o = int'({bus.bpm_hund, bus.bpm_tens, bus.bpm_ones});
    chk(tag, o, e);
  endtask

  // Compare every beat/click/LED output with the time-based model, then advance one clock.
  task automatic mstep();
    int p, li, idx, e, o;
    bit tk, sp, ac;
    p   = m_t / m_step;
    li  = (p < NUM_LEDS) ? p : SWEEP - p;
    idx = m_beat % BPB;
    tk  = (m_t == 0);
    sp  = m_t < ((idx == 0) ? 2 * CLICK_CYCLES : CLICK_CYCLES);
    ac  = sp && (idx == 0);
    e   = (int'(tk) << 8) | (idx << 6) | (int'(sp) << 5) | (int'(ac) << 4) | (1 << li);
    o   = int'({bus.beat_tick, bus.beat_idx, bus.speaker, bus.accent, bus.led});
    chk($sformatf("sweep b%0d t%0d", m_beat, m_t), o, e);
    tick();
    m_t++;
    if (m_t == m_step * SWEEP) begin
      m_t = 0;
      m_beat++;
      if (m_pend) begin
        m_step = m_next;
        m_pend = 0;
      end
    end
  endtask

  task automatic mstart(input int b);
    #1;
    m_step = exp_step(b);
    m_t    = 0;
    m_beat = 0;
    m_pend = 0;
  endtask

  task automatic press(input bit up, input bit dn, input string tag);
    bus.bpm_up_n   = !up;
    bus.bpm_down_n = !dn;
    repeat (4) tick();
    bus.bpm_up_n   = 1'b1;
    bus.bpm_down_n = 1'b1;
    repeat (4) tick();
    if (up && !dn)      m_bpm = (m_bpm + 10 > 240) ? 240 : m_bpm + 10;
    else if (dn && !up) m_bpm = (m_bpm - 10 < 40) ? 40 : m_bpm - 10;
    chk(tag, int'(bus.bpm), m_bpm);
  endtask

  task automatic load(input int v);
    bus.bpm_in   = 8'(v);
    bus.bpm_load = 1'b1;
    tick();
    bus.bpm_load = 1'b0;
    m_bpm = clampb(v);
    chk($sformatf("load %0d", v), int'(bus.bpm), m_bpm);
    tick();
    chk_bcd("load bcd");
  endtask

  task automatic wait_busy_low(input int limit, input string tag);
    bit ok;
    ok = 1'b0;
    for (int i = 0; i < limit; i++) begin
      if (!bus.busy) begin
        ok = 1'b1;
        break;
      end
      tick();
    end
    chk(tag, int'(ok), 1);
  endtask

  task automatic chk_idle_outputs(input string tag);
    chk({tag, " tick"},  int'(bus.beat_tick), 0);
    chk({tag, " idx"},   int'(bus.beat_idx), 0);
    chk({tag, " spk"},   int'(bus.speaker), 0);
    chk({tag, " acc"},   int'(bus.accent), 0);
    chk({tag, " led"},   int'(bus.led), 0);
  endtask

  initial begin
    int n, off, tgt, v, highs;
    reset          = 1'b0;
    bus.run        = 1'b0;
    bus.bpm_up_n   = 1'b1;
    bus.bpm_down_n = 1'b1;
    bus.bpm_load   = 1'b0;
    bus.bpm_in     = 8'd0;
    m_bpm          = 120;
    repeat (3) tick();

    // reset state
    chk("rst bpm", int'(bus.bpm), 120);
    chk_bcd("rst bcd");
    chk_idle_outputs("rst");
    chk("rst busy", int'(bus.busy), 1);

    // release with run=1: 32 busy cycles, then beat 0 starts
    reset   = 1'b1;
    bus.run = 1'b1;
    n = 0;
    while (bus.busy && n < 100) begin
      n++;
      tick();
    end
    chk("busy cycles", n, 32);
    chk("first tick", int'(bus.beat_tick), 1);
    m_step = exp_step(120); m_t = 0; m_beat = 0; m_pend = 0;
    repeat (BPB * SWEEP * m_step + 1) mstep();

    // up press mid-beat: current beat keeps the old length, next one uses 130 bpm
    off = $urandom_range(450, 100);
    while (m_t != off) mstep();
    bus.bpm_up_n = 1'b0;
    repeat (6) mstep();
    bus.bpm_up_n = 1'b1;
    m_bpm  = m_bpm + 10;
    m_next = exp_step(m_bpm);
    m_pend = 1;
    tgt = m_beat + 2;
    while (!(m_beat == tgt && m_t == 3)) mstep();
    chk("mid bpm", int'(bus.bpm), 130);
    chk_bcd("mid bcd");

    // run drop mid-beat
    repeat (200) mstep();
    bus.run = 1'b0;
    tick();
    chk_idle_outputs("stop");

    // saturate upward from 120
    load(120);
    for (int i = 0; i < 13; i++) press(1'b1, 1'b0, $sformatf("up %0d", i));
    chk_bcd("up sat bcd");
    wait_busy_low(100, "up sat div");
    bus.run = 1'b1;
    mstart(m_bpm);
    repeat (2 * SWEEP * m_step + 1) mstep();
    bus.run = 1'b0;
    tick();

    // saturate downward
    for (int i = 0; i < 25; i++) press(1'b0, 1'b1, $sformatf("down %0d", i));
    chk_bcd("down sat bcd");
    wait_busy_low(100, "down sat div");
    bus.run = 1'b1;
    mstart(m_bpm);
    repeat (SWEEP * m_step + 1) mstep();
    bus.run = 1'b0;
    tick();

    // both keys in the same cycle
    press(1'b1, 1'b1, "both keys");
    chk("both keys busy", int'(bus.busy), 0);

    // direct loads with clamping, including random values
    load(250);
    load(7);
    for (int i = 0; i < 4; i++) load(int'($urandom_range(255, 0)));

    // press latency: bpm moves on the third clock after the key falls
    load(100);
    bus.bpm_up_n = 1'b0;
    tick();
    tick();
    chk("press early", int'(bus.bpm), 100);
    tick();
    chk("press lat", int'(bus.bpm), 110);
    bus.bpm_up_n = 1'b1;
    repeat (4) tick();
    m_bpm = 110;

    // load coincides with the press edge: load wins
    v = int'($urandom_range(200, 45));
    if (v == m_bpm + 10) v = v + 1;
    bus.bpm_up_n = 1'b0;
    tick();
    tick();
    bus.bpm_in   = 8'(v);
    bus.bpm_load = 1'b1;
    tick();
    bus.bpm_load = 1'b0;
    m_bpm = clampb(v);
    chk("load wins", int'(bus.bpm), m_bpm);
    bus.bpm_up_n = 1'b1;
    repeat (4) tick();
    chk("load wins hold", int'(bus.bpm), m_bpm);

    // second press during a divide: one continuous busy, one final result
    load(60);
    wait_busy_low(100, "pre restart div");
    bus.bpm_up_n = 1'b0;
    repeat (4) tick();
    chk("div started", int'(bus.busy), 1);
    bus.bpm_up_n = 1'b1;
    repeat (5) tick();
    bus.bpm_up_n = 1'b0;
    repeat (4) tick();
    bus.bpm_up_n = 1'b1;
    m_bpm = 80;
    chk("restart bpm", int'(bus.bpm), 80);
    wait_busy_low(100, "restart div");
    highs = 0;
    repeat (40) begin
      if (bus.busy) highs++;
      tick();
    end
    chk("no late busy", highs, 0);
    bus.run = 1'b1;
    mstart(m_bpm);
    off = $urandom_range(800, 30);
    while (!(m_beat == 2 && m_t == off)) mstep();

    // reset mid-beat
    reset = 1'b0;
    tick();
    m_bpm = 120;
    chk("mid rst bpm", int'(bus.bpm), 120);
    chk_bcd("mid rst bcd");
    chk_idle_outputs("mid rst");
    chk("mid rst busy", int'(bus.busy), 1);
    reset = 1'b1;
    repeat (3) tick();

    $display("%0d/%0d checks passed", passes, checks);
    $finish;
  end
endmodule
